// File: rtl/mul_arb_if.sv
// mul_arb_if: bundle of the request, multiplier and response channels of
// the shared-multiplier arbiter.
//   req_*   : two issue slots -> arbiter (valid/ready per slot)
//   mul_*   : arbiter stage-1 registers -> combinational multiplier, and
//             the multiplier product back (mul_result)
//   resp_*  : arbiter stage-2 registers -> consumer (valid/ready)
// slave  : the arbiter's view.  master : the environment's view.
interface mul_arb_if #(
  parameter int TAG_W = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][3:0]       req_op;
  logic [1:0][31:0]      req_rdata1;
  logic [1:0][31:0]      req_rdata2;
  logic [1:0][TAG_W-1:0] req_tag;

  logic [3:0]            mul_op;
  logic [31:0]           mul_rdata1;
  logic [31:0]           mul_rdata2;
  logic [31:0]           mul_result;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_src;
  logic [TAG_W-1:0]      resp_tag;
  logic [31:0]           resp_result;

  modport slave (
    input  req_valid, req_op, req_rdata1, req_rdata2, req_tag,
    input  mul_result, resp_ready,
    output req_ready, mul_op, mul_rdata1, mul_rdata2,
    output resp_valid, resp_src, resp_tag, resp_result
  );

  modport master (
    output req_valid, req_op, req_rdata1, req_rdata2, req_tag,
    output mul_result, resp_ready,
    input  req_ready, mul_op, mul_rdata1, mul_rdata2,
    input  resp_valid, resp_src, resp_tag, resp_result
  );
endinterface

// File: rtl/mul_arb.sv
// mul_arb: round-robin arbiter and two-stage pipeline controller for a
// shared 32-bit multiplier serving two issue slots.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   kill  : flush; drops everything in flight and blocks same-cycle accepts
//   bus   : mul_arb_if.slave (request, multiplier and response channels)
// Stage 1 holds the granted op/operands and drives the multiplier; stage 2
// captures the product and presents it on the response channel.
module mul_arb #(
  parameter int TAG_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kill,
  mul_arb_if.slave   bus
);

  logic             ptr;
  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [31:0]      s1_rdata1;
  logic [31:0]      s1_rdata2;
  logic             s1_src;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic [31:0]      s2_result;
  logic             s2_src;
  logic [TAG_W-1:0] s2_tag;

  logic [1:0] grant;
  logic       s2_free;
  logic       s1_free;
  logic       s1_adv;
  logic       accept;
  logic       acc_src;
  logic       resp_hs;

  assign s2_free = !s2_valid || bus.resp_ready;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s2_free;
  assign resp_hs = s2_valid && bus.resp_ready;

  // Grant looks at req_valid only; the pointer breaks ties.
  always_comb begin
    grant = bus.req_valid;
    if (&bus.req_valid) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Reset gates ready combinationally so it drops the moment reset asserts.
  assign bus.req_ready = grant & {2{s1_free && !kill && reset}};

  // req_ready is one-hot or zero, so bit 1 identifies the accepted slot.
  assign accept  = |(bus.req_valid & bus.req_ready);
  assign acc_src = bus.req_ready[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= 1'b0;
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_rdata1 <= '0;
      s1_rdata2 <= '0;
      s1_src    <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_src    <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (accept) begin
        ptr       <= ~acc_src;
        s1_op     <= bus.req_op[acc_src];
        s1_rdata1 <= bus.req_rdata1[acc_src];
        s1_rdata2 <= bus.req_rdata2[acc_src];
        s1_src    <= acc_src;
        s1_tag    <= bus.req_tag[acc_src];
      end

      if (kill) begin
        s1_valid <= 1'b0;
      end else if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      // Data may load during kill; the cleared valid makes it invisible.
      if (s1_adv) begin
        s2_result <= bus.mul_result;
        s2_src    <= s1_src;
        s2_tag    <= s1_tag;
      end

      if (kill) begin
        s2_valid <= 1'b0;
      end else if (s1_adv) begin
        s2_valid <= 1'b1;
      end else if (resp_hs) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.mul_op      = s1_op;
  assign bus.mul_rdata1  = s1_rdata1;
  assign bus.mul_rdata2  = s1_rdata2;
  assign bus.resp_valid  = s2_valid;
  assign bus.resp_src    = s2_src;
  assign bus.resp_tag    = s2_tag;
  assign bus.resp_result = s2_result;

endmodule
